dem20_down: RTL and testbench

- Loadable cascaded down-counter. Complements the team's up-counting Dem4/Dem5/Dem20 chain.
- Two digits: low digit mod LO_MOD, high digit mod HI_MOD. Both step down from a loaded value to zero, then pulse a terminal borrow.
- Serves as the countdown/timeout side of the mod-20 timebase; consumers use `ra` as the expiry strobe.

---
 rtl/dem_pkg.sv | 19 +
 rtl/dem_digit_down.sv | 35 +++
 rtl/dem20_down.sv | 109 ++++++++++
 tb/tb_dem20_down.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/dem_pkg.sv
// Shared types and constant helpers for the dem down-counter family.
package dem_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    // Largest count a LO x HI cascade can hold; loads above it saturate here.
    function automatic int sat_max(input int lo_mod, input int hi_mod);
        return lo_mod * hi_mod - 1;
    endfunction

    function automatic int unsigned dig_lo(input int unsigned v, input int unsigned lo_mod);
        return v % lo_mod;
    endfunction

    function automatic int unsigned dig_hi(input int unsigned v, input int unsigned lo_mod);
        return v / lo_mod;
    endfunction

endpackage

// File: rtl/dem_digit_down.sv
// Single loadable mod-N down digit; bo flags a 0 -> N-1 step.
module dem_digit_down #(
    parameter int N  = 4,
    parameter int WD = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic [WD-1:0] ld_val,
    input  logic          dec,
    output logic [WD-1:0] q,
    output logic [WD-1:0] q_nxt,
    output logic          bo
);

    logic [WD-1:0] r_q;

    // bo ignores ld so the cascade can feed the load decision without a loop.
    assign bo = dec & (r_q == '0);
    assign q  = r_q;

    always_comb begin
        q_nxt = r_q;
        if (ld)
            q_nxt = ld_val;
        else if (dec)
            q_nxt = (r_q == '0) ? WD'(N - 1) : r_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q <= '0;
        else     r_q <= q_nxt;
    end

endmodule

// File: rtl/dem20_down.sv
// Loadable two-digit cascaded down-counter with expiry strobe ra.
// Define AUTO_RELOAD_EN to reload from the last loaded value at expiry.
module dem20_down
    import dem_pkg::*;
#(
    parameter int LO_MOD = 4,
    parameter int HI_MOD = 5,
    parameter int W      = 5,
    parameter int LW     = 2,
    parameter int HW     = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          en,
    output logic [W-1:0]  q,
    output logic [LW-1:0] q_lo,
    output logic [HW-1:0] q_hi,
    output logic          ra,
    output logic          busy
);

    localparam logic [W-1:0] MAXV = W'(sat_max(LO_MOD, HI_MOD));

    state_t        r_state;
    logic [W-1:0]  r_q;
    logic          r_ra;
    logic          r_busy;

    logic [W-1:0]  w_sat;
    logic [W-1:0]  w_ld_v;
    logic          w_ld;
    logic          w_dec_lo;
    logic          w_dec_hi;
    logic          w_bo_lo;
    logic          w_term;
    logic [LW-1:0] w_lo_nxt;
    logic [HW-1:0] w_hi_nxt;

    assign w_sat    = (32'(load_val) > 32'(MAXV)) ? MAXV : load_val;
    assign w_dec_lo = (r_state == ST_RUN) & en & ~load;
    assign w_dec_hi = w_bo_lo & en;

`ifdef AUTO_RELOAD_EN
    logic [W-1:0] r_reload;

    assign w_ld_v = load ? w_sat : r_reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_reload <= '0;
        else if (load) r_reload <= w_sat;
    end
`else
    // Expiry loads zero so the digits park at 0 instead of wrapping.
    assign w_ld_v = load ? w_sat : '0;
`endif

    // A borrow out of the high digit means the whole count stepped below zero.
    assign w_ld = load | w_term;

    dem_digit_down #(.N(LO_MOD), .WD(LW)) u_lo (
        .clk    (clk),
        .rst    (rst),
        .ld     (w_ld),
        .ld_val (LW'(dig_lo(32'(w_ld_v), LO_MOD))),
        .dec    (w_dec_lo),
        .q      (q_lo),
        .q_nxt  (w_lo_nxt),
        .bo     (w_bo_lo)
    );

    dem_digit_down #(.N(HI_MOD), .WD(HW)) u_hi (
        .clk    (clk),
        .rst    (rst),
        .ld     (w_ld),
        .ld_val (HW'(dig_hi(32'(w_ld_v), LO_MOD))),
        .dec    (w_dec_hi),
        .q      (q_hi),
        .q_nxt  (w_hi_nxt),
        .bo     (w_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_ra    <= 1'b0;
            r_q     <= '0;
        end else begin
            r_q  <= W'(w_hi_nxt) * W'(LO_MOD) + W'(w_lo_nxt);
            r_ra <= w_term;
            if (load) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
            end else if (w_term) begin
`ifndef AUTO_RELOAD_EN
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
`endif
            end
        end
    end

    assign q    = r_q;
    assign ra   = r_ra;
    assign busy = r_busy;

endmodule

// File: tb/tb_dem20_down.sv
// Directed + random bench for dem20_down against an integer countdown model.
module tb_dem20_down;

    localparam int LO = 4;
    localparam int HI = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [4:0] load_val = '0;
    logic       en = 1'b0;
    logic [4:0] q;
    logic [1:0] q_lo;
    logic [2:0] q_hi;
    logic       ra;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int m_cnt = 0, m_reload = 0;
    bit m_run = 0, m_ra = 0;

    dem20_down dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
        .q(q), .q_lo(q_lo), .q_hi(q_hi), .ra(ra), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q"},    32'(q),    32'(m_cnt));
        chk({tag, ".lo"},   32'(q_lo), 32'(m_cnt % LO));
        chk({tag, ".hi"},   32'(q_hi), 32'(m_cnt / LO));
        chk({tag, ".ra"},   32'(ra),   32'(m_ra));
        chk({tag, ".busy"}, 32'(busy), 32'(m_run));
    endtask

    task automatic model_reset();
        m_cnt = 0; m_reload = 0; m_run = 0; m_ra = 0;
    endtask

    // One clock: drive at negedge, update the model at the edge, check just after.
    task automatic cyc(input string tag, input bit ld, input int v, input bit e);
        @(negedge clk);
        load = ld; load_val = 5'(v); en = e;
        @(posedge clk);
        m_ra = 0;
        if (ld) begin
            m_cnt = (v > LO*HI-1) ? LO*HI-1 : v;
            m_reload = m_cnt;
            m_run = 1;
        end else if (m_run && e) begin
            if (m_cnt == 0) begin
                m_ra = 1;
`ifdef AUTO_RELOAD_EN
                m_cnt = m_reload;
`else
                m_run = 0;
`endif
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        int ra_cnt;
        #12;
        model_reset();
        chk_all("reset");
        @(negedge clk); rst = 1'b0;
        cyc("idle_en", 0, 0, 1);

        // Async reset mid-count at 13
        cyc("ld15", 1, 15, 0);
        cyc("dn14", 0, 0, 1);
        cyc("dn13", 0, 0, 1);
        @(negedge clk); en = 1'b1; #2 rst = 1'b1; #1;
        model_reset();
        chk_all("async_rst");
        @(negedge clk); rst = 1'b0;
        cyc("post_rst0", 0, 0, 1);
        cyc("post_rst1", 0, 0, 1);

        // 9 -> 0 then expiry on the 10th enabled edge
        cyc("ld9", 1, 9, 1);
        for (int i = 0; i < 12; i++) cyc("run9", 0, 0, 1);

        // Saturating load, 20 enabled cycles to ra
        cyc("ld25", 1, 25, 1);
        ra_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc("run19", 0, 0, 1);
            if (ra) ra_cnt++;
        end
        chk("sat_ra_at_20", 32'(ra), 32'd1);
        chk("sat_ra_once", 32'(ra_cnt), 32'd1);

        // Enable toggling from 4
        cyc("ld4", 1, 4, 0);
        for (int i = 0; i < 12; i++) cyc("tog", 0, 0, i % 2 == 0);

        // Load coincident with the terminal event
        cyc("ld0", 1, 0, 0);
        cyc("ld_term", 1, 7, 1);
        chk("ld_term_q7", 32'(q), 32'd7);
        cyc("after", 0, 0, 1);

        // load_val=0 expires on the next enabled cycle
        cyc("ld0b", 1, 0, 1);
        cyc("zero_term", 0, 0, 1);
        cyc("zero_after", 0, 0, 1);

`ifdef AUTO_RELOAD_EN
        cyc("ar_ld3", 1, 3, 1);
        for (int i = 0; i < 12; i++) cyc("ar_run", 0, 0, 1);
        cyc("ar_ld0", 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc("ar_zero", 0, 0, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            bit ld_r;
            ld_r = ($urandom_range(0, 9) == 0);
            cyc("rand", ld_r, int'($urandom_range(0, 31)), $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
